// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues req/ack fetches to instruction memory and
// holds each fetched word for decode, handling redirects, squashes and ack timeout.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        squash_q, squash_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & ~32'h0000_0003;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    squash_d   = squash_q;
    tmo_d      = tmo_q;
    case (state_q)
      IDLE: begin
        if (redirect) pc_d = redir_pc;
        state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          tmo_d = 8'd0;
          if (redirect) begin
            pc_d     = redir_pc;
            squash_d = 1'b0;
          end else if (squash_q) begin
            pc_d     = pend_pc_q;
            squash_d = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = HOLD;
          end
        end else begin
          // The address must stay put until the outstanding request is acked,
          // so a redirect here is parked and applied when that ack arrives.
          if (redirect) begin
            pend_pc_d = redir_pc;
            squash_d  = 1'b1;
          end
          tmo_d = tmo_q + 8'd1;
          if (tmo_q + 8'd1 == TMO_LIMIT) state_d = FAULT;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (!stall) begin
          state_d = REQ;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == REQ);
    valid_d = (state_d == HOLD);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      squash_q   <= 1'b0;
      tmo_q      <= 8'd0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      squash_q   <= squash_d;
      tmo_q      <= tmo_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_fault = fault_q;

endmodule
